sha1_board_ctrl: RTL and testbench
==================================

Name: sha1_board_ctrl

Overview:
Parametrised board-level control front-end for the SHA-1 accelerator.
- Debounces N raw push buttons and converts presses to one-cycle pulses.
- Launches a hash run on the SHA-1 core and captures the returned digest.
- Pages the captured digest onto an LED bank one slice at a time.
- Sits between the FPGA pins and the SHA-1 system instance, replacing direct pin-to-export wiring.

Parameters:
NUM_PB, 2, number of push buttons (>=2; pb[0]=start, pb[1]=next, others pulse-only)
DEBOUNCE_CYCLES, 50000, stable cycles required before a debounced level changes (1 ms at 50 MHz)
LED_W, 8, LED bank width = digest slice width
DIGEST_W, 160, digest width from core
TIMEOUT_CYCLES, 1000000, watchdog limit (used only with the optional feature)

Ports:
clk  input  1  system clock
reset_n  input  1  asynchronous active-low reset
push_button  input  NUM_PB  raw buttons, active-low (pressed = 0), asynchronous to clk
pb_pulse  output  NUM_PB  one-cycle pulse per debounced press
core_start  output  1  one-cycle start strobe to SHA-1 core
core_done  input  1  core completion strobe/level
core_digest  input  DIGEST_W  core result, valid while core_done=1
q  output  LED_W  LED drive
slice_idx  output  $clog2(NUM_SLICES)  currently displayed slice
busy  output  1  high in BUSY state

Behaviour:
- Reset is asynchronous and active-low. While reset_n=0, all outputs are 0, state=IDLE, slice_idx=0, digest register=0, and sync/debounce stages read "released" (1).
- Sync: two-flop synchroniser per button.
- Debounce, per button:
  - The counter restarts whenever the synced level differs from the debounced level.
  - When the count reaches DEBOUNCE_CYCLES-1 with the level still differing, the debounced level updates.
  - Press-to-pulse latency: 2 sync cycles + DEBOUNCE_CYCLES + 1 cycle.
- pb_pulse[i]: 1 for exactly one cycle on the debounced 1->0 transition. Release produces no pulse. Holding a button produces one pulse only.
- NUM_SLICES = ceil(DIGEST_W/LED_W).
  - Slice k = digest[DIGEST_W-1-k*LED_W -: LED_W]; slice 0 holds the MSBs.
  - For the last slice, bits below digest bit 0 read 0.
- FSM states: IDLE, BUSY, SHOW.
  - IDLE: q=0, busy=0. On pb_pulse[0]: core_start=1 for that single cycle, next state BUSY.
  - BUSY: busy=1, q=all-ones. core_done=1 latches core_digest, sets slice_idx=0, next state SHOW. pb_pulse[0] and pb_pulse[1] are ignored.
  - SHOW: q=slice(slice_idx). pb_pulse[1] increments slice_idx, wrapping from NUM_SLICES-1 to 0. pb_pulse[0] issues core_start, sets slice_idx=0, next state BUSY.
- Simultaneous events:
  - In SHOW, pb_pulse[0] together with pb_pulse[1]: start wins, no increment.
  - core_done is sampled only in BUSY. It is ignored in IDLE and SHOW and in the cycle core_start is issued.
- All outputs are registered except q, which is a mux of registered state, digest and slice_idx.
- Reset asserted mid-run (BUSY or SHOW) returns to IDLE immediately. The captured digest is cleared.

Optional Feature:
SHA1_CTRL_WDOG_EN:
- Defined:
  - A watchdog counter runs in BUSY only.
  - If it reaches TIMEOUT_CYCLES without core_done, the FSM enters state ERR.
  - ERR: q = alternating pattern starting 1010... (0xAA for LED_W=8), busy=0.
  - pb_pulse[0] in ERR issues core_start and re-enters BUSY with the counter cleared. pb_pulse[1] is ignored.
- Undefined: no counter, no ERR state. BUSY waits indefinitely for core_done.

Test Plan:
- Reset/idle, DEBOUNCE_CYCLES=4: hold reset_n=0 then release, buttons idle (all 1) -> q=0x00, busy=0, core_start=0, pb_pulse=0.
- Debounce: toggle push_button[1] 0/1 every 2 cycles for 20 cycles, then hold 0 -> no pb_pulse during glitching. Exactly one pb_pulse[1] appears 2+4+1 cycles after the stable hold; none on release.
- Hash run: press pb[0] -> one-cycle core_start, busy=1, q=0xFF. Drive core_done=1 with core_digest=0xA9993E364706816ABA3E25717850C26C9CD0D89D -> q=0xA9, slice_idx=0.
- Paging/wrap: from SHOW, 19 next presses -> q=0x9D, slice_idx=19. 20th press -> q=0xA9, slice_idx=0.
- Simultaneous/restart: in SHOW at slice_idx=5, start and next pulse in the same cycle -> core_start=1, slice_idx=0, BUSY. A core_done pulse in IDLE has no effect.
- Watchdog (SHA1_CTRL_WDOG_EN, TIMEOUT_CYCLES=16): start, withhold core_done -> ERR after 16 BUSY cycles with q=0xAA. Start press -> core_start, busy=1. Reset mid-BUSY -> IDLE, q=0x00.

Source files
------------

// File: rtl/sha1_board_ctrl.sv
// Board front-end for the SHA-1 core: button debounce/pulse, hash launch, digest paging on LEDs.
// Optional watchdog with ERR state is compiled in when SHA1_CTRL_WDOG_EN is defined.
module sha1_board_ctrl #(
    parameter int NUM_PB          = 2,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int LED_W           = 8,
    parameter int DIGEST_W        = 160,
    parameter int TIMEOUT_CYCLES  = 1000000,
    localparam int NUM_SLICES     = (DIGEST_W + LED_W - 1) / LED_W,
    localparam int SLICE_W        = (NUM_SLICES > 1) ? $clog2(NUM_SLICES) : 1
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [NUM_PB-1:0]   push_button,
    output logic [NUM_PB-1:0]   pb_pulse,
    output logic                core_start,
    input  logic                core_done,
    input  logic [DIGEST_W-1:0] core_digest,
    output logic [LED_W-1:0]    q,
    output logic [SLICE_W-1:0]  slice_idx,
    output logic                busy
);

    localparam int DB_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int TOTAL_W = NUM_SLICES * LED_W;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUSY,
        ST_SHOW
`ifdef SHA1_CTRL_WDOG_EN
        , ST_ERR
`endif
    } state_t;

    logic [NUM_PB-1:0] sync1_q, sync2_q;
    logic [NUM_PB-1:0] deb_q, deb_d, deb_prev_q;
    logic [NUM_PB-1:0] pb_pulse_q, pb_pulse_d;

    // Buttons are active-low, so the debounced 1->0 edge is a press.
    assign pb_pulse_d = deb_prev_q & ~deb_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q    <= '1;
            sync2_q    <= '1;
            deb_q      <= '1;
            deb_prev_q <= '1;
            pb_pulse_q <= '0;
        end else begin
            sync1_q    <= push_button;
            sync2_q    <= sync1_q;
            deb_q      <= deb_d;
            deb_prev_q <= deb_q;
            pb_pulse_q <= pb_pulse_d;
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_PB; gi++) begin : g_deb
            logic [DB_W-1:0] cnt_q, cnt_d;
            logic            lvl_d;

            always_comb begin
                cnt_d = '0;
                lvl_d = deb_q[gi];
                if (sync2_q[gi] != deb_q[gi]) begin
                    if (cnt_q == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                        lvl_d = sync2_q[gi];
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end

            assign deb_d[gi] = lvl_d;

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_d;
                end
            end
        end
    endgenerate

    state_t                state_q, state_d;
    logic [SLICE_W-1:0]    slice_idx_q, slice_idx_d;
    logic [DIGEST_W-1:0]   digest_q, digest_d;
    logic                  core_start_q, core_start_d;
    logic                  busy_q, busy_d;
    logic                  start_ev, next_ev;

    assign start_ev = pb_pulse_d[0];
    assign next_ev  = pb_pulse_d[1];

`ifdef SHA1_CTRL_WDOG_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [WD_W-1:0] wdog_q, wdog_d;
`endif

    always_comb begin
        state_d      = state_q;
        slice_idx_d  = slice_idx_q;
        digest_d     = digest_q;
        core_start_d = 1'b0;
`ifdef SHA1_CTRL_WDOG_EN
        wdog_d       = '0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start_ev) begin
                    core_start_d = 1'b1;
                    state_d      = ST_BUSY;
                end
            end
            ST_BUSY: begin
                // The cycle that carries core_start cannot also accept a completion.
                if (core_done && !core_start_q) begin
                    digest_d    = core_digest;
                    slice_idx_d = '0;
                    state_d     = ST_SHOW;
                end
`ifdef SHA1_CTRL_WDOG_EN
                else if (wdog_q == WD_W'(TIMEOUT_CYCLES - 1)) begin
                    state_d = ST_ERR;
                end else begin
                    wdog_d = wdog_q + 1'b1;
                end
`endif
            end
            ST_SHOW: begin
                if (start_ev) begin
                    core_start_d = 1'b1;
                    slice_idx_d  = '0;
                    state_d      = ST_BUSY;
                end else if (next_ev) begin
                    slice_idx_d = (slice_idx_q == SLICE_W'(NUM_SLICES - 1)) ? '0 : slice_idx_q + 1'b1;
                end
            end
`ifdef SHA1_CTRL_WDOG_EN
            ST_ERR: begin
                if (start_ev) begin
                    core_start_d = 1'b1;
                    state_d      = ST_BUSY;
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase
        busy_d = (state_d == ST_BUSY);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            slice_idx_q  <= '0;
            digest_q     <= '0;
            core_start_q <= 1'b0;
            busy_q       <= 1'b0;
`ifdef SHA1_CTRL_WDOG_EN
            wdog_q       <= '0;
`endif
        end else begin
            state_q      <= state_d;
            slice_idx_q  <= slice_idx_d;
            digest_q     <= digest_d;
            core_start_q <= core_start_d;
            busy_q       <= busy_d;
`ifdef SHA1_CTRL_WDOG_EN
            wdog_q       <= wdog_d;
`endif
        end
    end

    // Left-align the digest so slice 0 is the MSBs and the last slice is zero-filled.
    logic [TOTAL_W-1:0] padded_digest;
    logic [LED_W-1:0]   slice_val;

    always_comb begin
        padded_digest = '0;
        padded_digest[TOTAL_W-1 -: DIGEST_W] = digest_q;
    end

    always_comb begin
        slice_val = '0;
        for (int k = 0; k < NUM_SLICES; k++) begin
            if (slice_idx_q == SLICE_W'(k)) begin
                slice_val = padded_digest[TOTAL_W-1-k*LED_W -: LED_W];
            end
        end
    end

`ifdef SHA1_CTRL_WDOG_EN
    logic [LED_W-1:0] err_pat;
    generate
        for (genvar gi = 0; gi < LED_W; gi++) begin : g_err_pat
            assign err_pat[gi] = ((LED_W - 1 - gi) % 2) == 0;
        end
    endgenerate
`endif

    always_comb begin
        q = '0;
        case (state_q)
            ST_BUSY: q = '1;
            ST_SHOW: q = slice_val;
`ifdef SHA1_CTRL_WDOG_EN
            ST_ERR:  q = err_pat;
`endif
            default: q = '0;
        endcase
    end

    assign pb_pulse   = pb_pulse_q;
    assign core_start = core_start_q;
    assign slice_idx  = slice_idx_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_sha1_board_ctrl.sv
// Directed/random bench for sha1_board_ctrl against a state-level reference model.
module tb_sha1_board_ctrl;
    localparam int NPB  = 2;
    localparam int DEB  = 4;
    localparam int LW   = 8;
    localparam int DW   = 160;
    localparam int TMO  = 16;
    localparam int NS   = (DW + LW - 1) / LW;
    localparam int SW   = $clog2(NS);
    localparam int PADW = NS * LW - DW;

    localparam int M_IDLE = 0, M_BUSY = 1, M_SHOW = 2, M_ERR = 3;

    logic            clk = 1'b0;
    logic            reset_n;
    logic [NPB-1:0]  push_button;
    logic [NPB-1:0]  pb_pulse;
    logic            core_start;
    logic            core_done;
    logic [DW-1:0]   core_digest;
    logic [LW-1:0]   q;
    logic [SW-1:0]   slice_idx;
    logic            busy;

    sha1_board_ctrl #(
        .NUM_PB(NPB), .DEBOUNCE_CYCLES(DEB), .LED_W(LW), .DIGEST_W(DW), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk), .reset_n(reset_n), .push_button(push_button), .pb_pulse(pb_pulse),
        .core_start(core_start), .core_done(core_done), .core_digest(core_digest),
        .q(q), .slice_idx(slice_idx), .busy(busy)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    int          mstate;
    int          mslice;
    logic [DW-1:0] mdigest;

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
        $display("check %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    function automatic logic [LW-1:0] model_q();
        logic [NS*LW-1:0] wide;
        case (mstate)
            M_IDLE: return '0;
            M_BUSY: return '1;
            M_ERR:  return 8'hAA;
            default: begin
                wide = '0;
                wide = wide | mdigest;
                wide = wide << PADW;
                wide = wide >> ((NS - 1 - mslice) * LW);
                return wide[LW-1:0];
            end
        endcase
    endfunction

    task automatic check_model(input string tag);
        check({tag, "_q"}, q, model_q());
        check({tag, "_busy"}, busy, (mstate == M_BUSY));
        check({tag, "_slice"}, slice_idx, mslice);
    endtask

    task automatic model_reset();
        mstate  = M_IDLE;
        mslice  = 0;
        mdigest = '0;
    endtask

    function automatic logic [DW-1:0] rand_digest();
        logic [DW-1:0] d;
        d = '0;
        for (int w = 0; w < (DW + 31) / 32; w++) d = (d << 32) | DW'($urandom);
        return d;
    endfunction

    // Hold the buttons in mask low until the debounced pulse is due, then release.
    task automatic press(input logic [NPB-1:0] mask, input string tag);
        logic [NPB-1:0] early;
        logic           exp_start;
        early     = '0;
        exp_start = 1'b0;
        @(negedge clk);
        push_button = ~mask;
        repeat (2 + DEB) begin
            @(posedge clk);
            #1 early |= pb_pulse;
        end
        @(posedge clk);
        #1;
        if (mask[0] && mstate != M_BUSY) begin
            exp_start = 1'b1;
            mstate    = M_BUSY;
            mslice    = 0;
        end else if (mask[1] && mstate == M_SHOW) begin
            mslice = (mslice + 1) % NS;
        end
        check({tag, "_early"}, early, 0);
        check({tag, "_pulse"}, pb_pulse, mask);
        check({tag, "_start"}, core_start, exp_start);
        check_model(tag);
        push_button = '1;
    endtask

    task automatic settle(input string tag);
        logic any;
        any = 1'b0;
        repeat (DEB + 4) begin
            @(posedge clk);
            #1 any |= (|pb_pulse) | core_start;
        end
        check({tag, "_quiet"}, any, 0);
    endtask

    task automatic done(input logic [DW-1:0] d, input string tag);
        @(negedge clk);
        core_done   = 1'b1;
        core_digest = d;
        @(posedge clk);
        #1;
        if (mstate == M_BUSY) begin
            mdigest = d;
            mslice  = 0;
            mstate  = M_SHOW;
        end
        check_model(tag);
        @(negedge clk);
        core_done   = 1'b0;
        core_digest = rand_digest();
    endtask

    task automatic reset_now(input string tag);
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        model_reset();
        check({tag, "_q"}, q, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_start"}, core_start, 0);
        check({tag, "_pulse"}, pb_pulse, 0);
        check({tag, "_slice"}, slice_idx, 0);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1 check_model({tag, "_after"});
    endtask

    initial begin
        logic [NPB-1:0] glitch;
        int             lat;
        int             npulse;
        int             n_next;

        push_button = '1;
        core_done   = 1'b0;
        core_digest = '0;
        reset_n     = 1'b0;
        model_reset();

        repeat (3) @(negedge clk);
        check("rst_q", q, 0);
        check("rst_busy", busy, 0);
        check("rst_start", core_start, 0);
        check("rst_pulse", pb_pulse, 0);
        check("rst_slice", slice_idx, 0);
        reset_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("idle_q", q, 0);
        check("idle_busy", busy, 0);
        check("idle_start", core_start, 0);
        check("idle_pulse", pb_pulse, 0);

        // Bounce shorter than the debounce window must never pulse.
        glitch = '0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            push_button[1] = ((c / 2) % 2) != 0;
            @(posedge clk);
            #1 glitch |= pb_pulse;
        end
        check("glitch_pulse", glitch, 0);
        @(negedge clk);
        push_button[1] = 1'b0;
        lat    = -1;
        npulse = 0;
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk);
            #1;
            if (pb_pulse[1] && lat < 0) lat = n;
            if (|pb_pulse) npulse++;
        end
        check("hold_latency", lat, 2 + DEB + 1);
        check("hold_npulse", npulse, 1);
        check_model("hold_idle");
        push_button = '1;
        settle("release");

        done(rand_digest(), "idle_done");

        press(2'b01, "start1");
        @(negedge clk);
        core_done   = 1'b1;
        core_digest = rand_digest();
        @(posedge clk);
        #1 check_model("done_on_start");
        @(negedge clk);
        core_done = 1'b0;
        settle("start1");

        done(160'hA9993E364706816ABA3E25717850C26C9CD0D89D, "known");
        check("known_slice0", q, 8'hA9);
        for (int i = 0; i < NS - 1; i++) begin
            press(2'b10, "page");
            settle("page");
        end
        check("page_last_q", q, 8'h9D);
        check("page_last_idx", slice_idx, NS - 1);
        press(2'b10, "wrap");
        check("wrap_q", q, 8'hA9);
        check("wrap_idx", slice_idx, 0);
        settle("wrap");

        for (int r = 0; r < 3; r++) begin
            press(2'b01, "rstart");
            settle("rstart");
            done(rand_digest(), "rdone");
            n_next = $urandom_range(1, NS + 4);
            for (int i = 0; i < n_next; i++) begin
                press(2'b10, "rnext");
                settle("rnext");
            end
        end

        for (int i = 0; i < NS && mslice != 5; i++) begin
            press(2'b10, "to5");
            settle("to5");
        end
        check("at5", slice_idx, 5);
        press(2'b11, "both");
        check("both_start", core_start, 1);
        check("both_idx", slice_idx, 0);
        check("both_busy", busy, 1);

`ifdef SHA1_CTRL_WDOG_EN
        repeat (TMO - 1) @(posedge clk);
        #1 check("wdog_pre_busy", busy, 1);
        @(posedge clk);
        #1;
        mstate = M_ERR;
        check_model("err");
        check("err_q", q, 8'hAA);
        settle("err");
        press(2'b10, "err_next");
        settle("err_next");
        press(2'b01, "err_start");
        check("err_start_busy", busy, 1);
`else
        repeat (TMO + 4) @(posedge clk);
        #1 check_model("no_wdog");
`endif
        reset_now("rst_busy_mid");

        press(2'b01, "s2");
        settle("s2");
        done(rand_digest(), "s2done");
        press(2'b10, "s2next");
        settle("s2next");
        reset_now("rst_show_mid");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog_timeout observed=running expected=finished");
        $fatal(1, "bench timeout");
    end
endmodule
